// File: rtl/lsu_split_pkg.sv
// lsu_pkg: shared types for the load/store splitter, including the mem access-type and errno codes.
// lsu_nbeats decides whether a request needs splitting and how many byte beats it takes.
package lsu_pkg;
    typedef enum logic [2:0] {
        MEM_DT_BYTE,
        MEM_DT_HALF,
        MEM_DT_WORD,
        MEM_DT_UBYTE,
        MEM_DT_UHALF
    } mem_dt_e;

    typedef enum logic [3:0] {
        ERR_OK         = 4'd0,
        ERR_MISALIGNED = 4'd1,
        ERR_RANGE      = 4'd2
    } errno_e;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} lsu_state_e;

    localparam int LSU_MAX_BEATS = 4;

    typedef struct packed {
        logic       mis;
        logic [2:0] nbeats;
    } lsu_split_t;

    function automatic lsu_split_t lsu_nbeats(input logic [1:0] a, input mem_dt_e dt);
        lsu_split_t s;
        s.mis    = ((dt == MEM_DT_HALF || dt == MEM_DT_UHALF) && a[0]) || (dt == MEM_DT_WORD && a != 2'b00);
        s.nbeats = !s.mis ? 3'd1 : (dt == MEM_DT_WORD ? 3'd4 : 3'd2);
        return s;
    endfunction
endpackage

// File: rtl/lsu_split_if.sv
// lsu_split_if: CPU-side request/response handshake of the load/store splitter.
interface lsu_split_if;
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic [31:0]          req_wd;
    logic                 req_we;
    lsu_pkg::mem_dt_e     req_dt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    lsu_pkg::errno_e      rsp_err;

    modport master (
        output req_valid, req_addr, req_wd, req_we, req_dt, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, req_wd, req_we, req_dt, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_split_rd_assemble.sv
// lsu_rd_assemble: collects load data per beat (whole word, or one byte lane per split beat)
// and applies the final sign/zero extension for split half loads.
module lsu_rd_assemble
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        cap,
    input  logic        split,
    input  logic [1:0]  k,
    input  mem_dt_e     dt,
    input  logic [31:0] rd,
    output logic [31:0] rdata
);
    logic [31:0] data_q, data_d, lane;

    always_comb begin
        lane   = 32'hFF << {k, 3'b000};
        data_d = clr ? '0 : !cap ? data_q :
                 split ? (data_q & ~lane) | ({24'b0, rd[7:0]} << {k, 3'b000}) : rd;
        rdata  = split && dt == MEM_DT_HALF  ? {{16{data_q[15]}}, data_q[15:0]} :
                 split && dt == MEM_DT_UHALF ? {16'b0, data_q[15:0]} : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end
endmodule

// File: rtl/lsu_split.sv
// lsu_split: load/store front end for strict-aligned mem; misaligned half/word accesses become UBYTE beats.
// Splitting needs CONFIG_LSU_SPLIT_MISALIGNED_EN; without it misaligned requests answer ERR_MISALIGNED at once.
module lsu_split
    import lsu_pkg::*;
#(
    parameter int MAX_BEATS = LSU_MAX_BEATS
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_split_if.slave  bus,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    output logic        m_we,
    output mem_dt_e     m_dt,
    input  logic [31:0] m_rd,
    input  errno_e      m_err
);
    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, wd_q, wd_d;
    logic        we_q, we_d, split_q, split_d;
    mem_dt_e     dt_q, dt_d;
    logic [2:0]  nbeats_q, nbeats_d;
    logic [1:0]  k_q, k_d;
    errno_e      err_q, err_d;
    lsu_split_t  sp;
    logic        clr, cap;

    always_comb begin
        sp            = lsu_nbeats(bus.req_addr[1:0], bus.req_dt);
        state_d       = state_q;
        addr_d        = addr_q;
        wd_d          = wd_q;
        we_d          = we_q;
        dt_d          = dt_q;
        split_d       = split_q;
        nbeats_d      = nbeats_q;
        k_d           = k_q;
        err_d         = err_q;
        clr           = 1'b0;
        cap           = 1'b0;
        bus.req_ready = state_q == IDLE;
        bus.rsp_valid = state_q == RESP;
        bus.rsp_err   = err_q;
        m_addr        = '0;
        m_wd          = '0;
        m_we          = 1'b0;
        m_dt          = MEM_DT_WORD;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d   = bus.req_addr;
                wd_d     = bus.req_wd;
                we_d     = bus.req_we;
                dt_d     = bus.req_dt;
                split_d  = sp.mis;
                nbeats_d = sp.nbeats;
                k_d      = 2'd0;
                clr      = 1'b1;
`ifdef CONFIG_LSU_SPLIT_MISALIGNED_EN
                err_d    = ERR_OK;
                state_d  = BEAT;
`else
                err_d    = sp.mis ? ERR_MISALIGNED : ERR_OK;
                state_d  = sp.mis ? RESP : BEAT;
`endif
            end
            BEAT: begin
                m_addr  = split_q ? addr_q + {30'b0, k_q} : addr_q;
                m_dt    = split_q ? MEM_DT_UBYTE : dt_q;
                m_wd    = split_q ? {24'b0, wd_q[{k_q, 3'b000} +: 8]} : wd_q;
                m_we    = we_q;
                cap     = !we_q;
                err_d   = errno_e'(err_q | m_err);
                k_d     = k_q + 2'd1;
                state_d = {1'b0, k_q} == nbeats_q - 3'd1 ? RESP : BEAT;
            end
            RESP: state_d = bus.rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            dt_q     <= MEM_DT_WORD;
            split_q  <= 1'b0;
            nbeats_q <= 3'd1;
            k_q      <= 2'd0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            dt_q     <= dt_d;
            split_q  <= split_d;
            nbeats_q <= nbeats_d;
            k_q      <= k_d;
            err_q    <= err_d;
        end
    end

    lsu_rd_assemble u_rd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .cap   (cap),
        .split (split_q),
        .k     (k_q),
        .dt    (dt_q),
        .rd    (m_rd),
        .rdata (bus.rsp_rdata)
    );

    assert property (@(posedge clk) disable iff (!rst_n) nbeats_q <= 3'(MAX_BEATS));
endmodule

// File: tb/tb_lsu_split.sv
// tb_lsu_split: directed bench for lsu_split against a strict-aligned little-endian mem model;
// split-access scenarios are built when CONFIG_LSU_SPLIT_MISALIGNED_EN is defined.
module tb_lsu_split;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_split_if bus();
    logic [31:0] m_addr, m_wd, m_rd;
    logic        m_we;
    mem_dt_e     m_dt;
    errno_e      m_err;

    lsu_split dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_dt(m_dt), .m_rd(m_rd), .m_err(m_err)
    );

    logic [31:0] mem_w [64];
    logic [31:0] mw, mb, mh;
    logic        mmis;
    int          errors = 0;
    int          checks = 0;

    always_comb begin
        mw    = mem_w[m_addr[7:2]];
        mb    = mw >> {m_addr[1:0], 3'b000};
        mh    = mw >> {m_addr[1], 4'b0000};
        mmis  = ((m_dt == MEM_DT_HALF || m_dt == MEM_DT_UHALF) && m_addr[0]) ||
                (m_dt == MEM_DT_WORD && m_addr[1:0] != 2'b00);
        m_err = mmis ? ERR_MISALIGNED : ERR_OK;
        m_rd  = m_dt == MEM_DT_BYTE  ? {{24{mb[7]}}, mb[7:0]} :
                m_dt == MEM_DT_UBYTE ? {24'b0, mb[7:0]} :
                m_dt == MEM_DT_HALF  ? {{16{mh[15]}}, mh[15:0]} :
                m_dt == MEM_DT_UHALF ? {16'b0, mh[15:0]} : mw;
        if (mmis) m_rd = '0;
    end

    always @(posedge clk) begin
        if (m_we && !mmis) begin
            if (m_dt == MEM_DT_WORD) mem_w[m_addr[7:2]] <= m_wd;
            else if (m_dt == MEM_DT_HALF || m_dt == MEM_DT_UHALF) mem_w[m_addr[7:2]][{m_addr[1], 4'b0000} +: 16] <= m_wd[15:0];
            else mem_w[m_addr[7:2]][{m_addr[1:0], 3'b000} +: 8] <= m_wd[7:0];
        end
    end

    logic [31:0] r_rd, r_addr;
    errno_e      r_er;
    int          r_lat;
    logic        r_we;
    mem_dt_e     r_dt;

    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic we, input mem_dt_e dt);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_wd = wd; bus.req_we = we; bus.req_dt = dt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        r_lat = 1; r_we = m_we; r_addr = m_addr; r_dt = m_dt;
        while (!bus.rsp_valid && r_lat < 20) begin
            r_we |= m_we;
            @(negedge clk);
            r_lat++;
        end
        if (r_lat >= 20) begin
            errors++; checks++;
            $display("FAIL rsp_timeout addr=%h got no rsp_valid within 20 cycles", a);
        end
        r_rd = bus.rsp_rdata; r_er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wd = '0; bus.req_we = 1'b0;
        bus.req_dt = MEM_DT_WORD; bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== ERR_OK) begin errors++; $display("FAIL reset_rsp_err got %0d exp 0", bus.rsp_err); end
        checks++; if ({m_we, m_addr, m_wd} !== 65'h0) begin errors++; $display("FAIL reset_mem_bus got we=%b addr=%h wd=%h exp 0", m_we, m_addr, m_wd); end
        checks++; if (m_dt !== MEM_DT_WORD) begin errors++; $display("FAIL reset_m_dt got %0d exp WORD", m_dt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_load;
        do_req(32'h10, 32'h0, 1'b0, MEM_DT_WORD);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL aligned_load_latency got %0d exp 2", r_lat); end
        checks++; if (r_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL aligned_load_rdata got %h exp deadbeef", r_rd); end
        checks++; if (r_er !== ERR_OK) begin errors++; $display("FAIL aligned_load_err got %0d exp 0", r_er); end
        checks++; if (r_dt !== MEM_DT_WORD || r_addr !== 32'h10) begin errors++; $display("FAIL aligned_load_beat got dt=%0d addr=%h exp WORD 10", r_dt, r_addr); end
    endtask

    task automatic test_aligned_store;
        do_req(32'h20, 32'h12345678, 1'b1, MEM_DT_WORD);
        checks++; if (mem_w[8] !== 32'h12345678) begin errors++; $display("FAIL store_word_mem got %h exp 12345678", mem_w[8]); end
        checks++; if (r_rd !== 32'h0 || r_er !== ERR_OK || r_we !== 1'b1) begin errors++; $display("FAIL store_word_rsp got rd=%h err=%0d we=%b exp 0 0 1", r_rd, r_er, r_we); end
        do_req(32'h21, 32'hFFFFFFA5, 1'b1, MEM_DT_BYTE);
        checks++; if (mem_w[8] !== 32'h1234A578) begin errors++; $display("FAIL store_byte_mem got %h exp 1234a578", mem_w[8]); end
        do_req(32'h22, 32'h0, 1'b0, MEM_DT_HALF);
        checks++; if (r_rd !== 32'h00001234) begin errors++; $display("FAIL load_half_rdata got %h exp 00001234", r_rd); end
        do_req(32'h21, 32'h0, 1'b0, MEM_DT_BYTE);
        checks++; if (r_rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL load_byte_rdata got %h exp ffffffa5", r_rd); end
        do_req(32'h21, 32'h0, 1'b0, MEM_DT_UBYTE);
        checks++; if (r_rd !== 32'h000000A5) begin errors++; $display("FAIL load_ubyte_rdata got %h exp 000000a5", r_rd); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h10; bus.req_we = 1'b0; bus.req_dt = MEM_DT_WORD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_err !== ERR_OK)
                begin errors++; $display("FAIL bp_hold%0d got v=%b rd=%h err=%0d exp 1 deadbeef 0", i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
            checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready%0d got %b exp 0", i, bus.req_ready); end
            bus.req_valid = i == 0; bus.req_addr = 32'h20;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0 1", bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1 || m_addr !== 32'h0) begin errors++; $display("FAIL bp_pulse_ignored got rdy=%b addr=%h exp 1 0", bus.req_ready, m_addr); end
    endtask

`ifdef CONFIG_LSU_SPLIT_MISALIGNED_EN
    task automatic test_split;
        do_req(32'h13, 32'hAABBCCDD, 1'b1, MEM_DT_WORD);
        checks++; if (r_lat !== 5 || r_er !== ERR_OK) begin errors++; $display("FAIL split_store_rsp got lat=%0d err=%0d exp 5 0", r_lat, r_er); end
        checks++; if (r_addr !== 32'h13 || r_dt !== MEM_DT_UBYTE) begin errors++; $display("FAIL split_store_beat0 got addr=%h dt=%0d exp 13 UBYTE", r_addr, r_dt); end
        do_req(32'h10, 32'h0, 1'b0, MEM_DT_WORD);
        checks++; if (r_rd !== 32'hDDADBEEF) begin errors++; $display("FAIL split_store_w10 got %h exp ddadbeef", r_rd); end
        do_req(32'h14, 32'h0, 1'b0, MEM_DT_WORD);
        checks++; if (r_rd !== 32'h00AABBCC) begin errors++; $display("FAIL split_store_w14 got %h exp 00aabbcc", r_rd); end
        do_req(32'h1, 32'h0, 1'b0, MEM_DT_HALF);
        checks++; if (r_lat !== 3 || r_rd !== 32'hFFFF8034) begin errors++; $display("FAIL split_half got lat=%0d rd=%h exp 3 ffff8034", r_lat, r_rd); end
        do_req(32'h1, 32'h0, 1'b0, MEM_DT_UHALF);
        checks++; if (r_rd !== 32'h00008034) begin errors++; $display("FAIL split_uhalf got %h exp 00008034", r_rd); end
        do_req(32'hFFFFFFFF, 32'h0, 1'b0, MEM_DT_WORD);
        checks++; if (r_lat !== 5 || r_rd !== 32'h80340011) begin errors++; $display("FAIL split_wrap got lat=%0d rd=%h exp 5 80340011", r_lat, r_rd); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h21; bus.req_wd = 32'hAABBCCDD; bus.req_we = 1'b1; bus.req_dt = MEM_DT_WORD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({m_we, m_addr, m_wd, bus.rsp_valid, bus.req_ready} !== {66'h0, 1'b1}) begin errors++; $display("FAIL reset_mid_outputs got we=%b addr=%h wd=%h v=%b rdy=%b exp 0 0 0 0 1", m_we, m_addr, m_wd, bus.rsp_valid, bus.req_ready); end
        repeat (3) @(negedge clk);
        checks++; if (mem_w[8] !== 32'h12CCDD78) begin errors++; $display("FAIL reset_mid_mem got %h exp 12ccdd78", mem_w[8]); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_no_rsp got v=%b rdy=%b exp 0 1", bus.rsp_valid, bus.req_ready); end
    endtask
`else
    task automatic test_misaligned;
        do_req(32'h2, 32'h0, 1'b0, MEM_DT_WORD);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL mis_load_latency got %0d exp 1", r_lat); end
        checks++; if (r_er !== ERR_MISALIGNED || r_rd !== 32'h0) begin errors++; $display("FAIL mis_load_rsp got err=%0d rd=%h exp 1 0", r_er, r_rd); end
        checks++; if (r_we !== 1'b0 || r_addr !== 32'h0) begin errors++; $display("FAIL mis_load_no_beat got we=%b addr=%h exp 0 0", r_we, r_addr); end
        do_req(32'h1, 32'hBEEF, 1'b1, MEM_DT_HALF);
        checks++; if (r_lat !== 1 || r_er !== ERR_MISALIGNED) begin errors++; $display("FAIL mis_store_rsp got lat=%0d err=%0d exp 1 1", r_lat, r_er); end
        checks++; if (mem_w[0] !== 32'h00803400 || r_we !== 1'b0) begin errors++; $display("FAIL mis_store_mem got %h we=%b exp 00803400 0", mem_w[0], r_we); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_addr = 32'h30; bus.req_wd = 32'h55667788; bus.req_we = 1'b1; bus.req_dt = MEM_DT_WORD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (m_we !== 1'b1 || m_addr !== 32'h30) begin errors++; $display("FAIL reset_mid_beat got we=%b addr=%h exp 1 30", m_we, m_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if ({m_we, m_addr, m_wd, bus.rsp_valid, bus.req_ready} !== {66'h0, 1'b1}) begin errors++; $display("FAIL reset_mid_outputs got we=%b addr=%h wd=%h v=%b rdy=%b exp 0 0 0 0 1", m_we, m_addr, m_wd, bus.rsp_valid, bus.req_ready); end
        repeat (3) @(negedge clk);
        checks++; if (mem_w[12] !== 32'h0) begin errors++; $display("FAIL reset_mid_mem got %h exp 0", mem_w[12]); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_no_rsp got v=%b rdy=%b exp 0 1", bus.rsp_valid, bus.req_ready); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem_w[i] <= 32'h0;
        mem_w[0]  <= 32'h00803400;
        mem_w[4]  <= 32'hDEADBEEF;
        mem_w[63] <= 32'h11000000;
        test_reset;
        test_aligned_load;
        test_aligned_store;
`ifndef CONFIG_LSU_SPLIT_MISALIGNED_EN
        test_misaligned;
`endif
        test_backpressure;
`ifdef CONFIG_LSU_SPLIT_MISALIGNED_EN
        test_split;
`endif
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
Load/store front end that sits directly upstream of the strict-aligned data memory `mem`. It accepts one load or store request at a time through a valid/ready handshake and drives `mem`'s addr/wd/we/dt inputs. A naturally aligned access is issued as a single beat. A misaligned half or word access is split into sequential unsigned-byte beats, and the read data is reassembled and sign-extended. The result returns on a valid/ready response channel, so the CPU never sees a misalignment error from `mem`.

Parameters:
- MAX_BEATS, 4, maximum byte beats per request (word size in bytes); fixed at 4, exposed only for assertions.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  32  byte address, any alignment.
- req_wd  in  32  store data, right-justified.
- req_we  in  1  1 = store, 0 = load.
- req_dt  in  mem_dt_e  access type (BYTE/HALF/WORD/UBYTE/UHALF).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  load data, extended per req_dt; 0 for stores.
- rsp_err  out  errno_e  0 = ok; nonzero = error.
- m_addr  out  32  to mem addr.
- m_wd  out  32  to mem wd.
- m_we  out  1  to mem we.
- m_dt  out  mem_dt_e  to mem dt.
- m_rd  in  32  from mem rd (asynchronous read).
- m_err  in  errno_e  from mem err.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - m_we=0, m_addr=0, m_wd=0, m_dt=MEM_DT_WORD.
- FSM states: IDLE, BEAT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at cycle T, register addr/wd/we/dt and compute the split:
    - mis = (HALF/UHALF and addr[0]) or (WORD and addr[1:0]!=0).
    - nbeats = 1 if !mis; 2 for HALF/UHALF; 4 for WORD.
  - Next state is BEAT, beat index k=0.
- BEAT:
  - req_ready=0. One beat per cycle, T+1 .. T+nbeats.
  - Aligned access (nbeats=1):
    - m_addr=addr, m_dt=dt, m_wd=wd, m_we=we.
    - Load: capture m_rd in full.
  - Split access, beat k:
    - m_addr = addr+k (mod 2^32), m_dt=MEM_DT_UBYTE, m_wd={24'b0, wd[8k+7:8k]}, m_we=we.
    - Load: capture m_rd[7:0] into data[8k+7:8k].
  - Any nonzero m_err in any beat is OR-latched into rsp_err; remaining beats still run.
  - After the last beat, go to RESP.
- RESP:
  - rsp_valid=1; m_we=0.
  - For split loads, rsp_rdata is extended at this point:
    - HALF: sign-extend bit 15.
    - UHALF: zero-extend.
    - WORD: unchanged.
  - Outputs are held stable while rsp_ready=0.
  - On rsp_ready, go to IDLE; no new request is accepted in the same cycle.
- Latency (accept to rsp_valid): 2 cycles aligned, 3 split half, 5 split word. Throughput is one request per nbeats+2 cycles.
- m_we is asserted only in BEAT; the address and data for each beat are stable for the whole cycle, and `mem` writes on that cycle's closing edge.
- Reset mid-request: immediate return to the reset values. Bytes already written by completed beats remain in memory; no response is produced.
- Address wrap: 0xFFFFFFFF word split → beats to 0xFFFFFFFF, 0x0, 0x1, 0x2. Range against `mem` N is the caller's responsibility.

Optional Feature:
CONFIG_LSU_SPLIT_MISALIGNED_EN
- Defined: misaligned accesses are split as described above.
- Undefined:
  - Misaligned requests skip BEAT and go straight to RESP at T+1.
  - No mem access is made (m_we stays 0).
  - rsp_rdata=0; rsp_err = errno_e value 1, the same misalignment code `mem` reports.
  - Aligned behaviour is unchanged.

Decomposition:
- Package lsu_pkg: lsu_state_e {IDLE, BEAT, RESP}; constant LSU_MAX_BEATS=4; function lsu_nbeats(addr[1:0], dt) returning 1/2/4 and the mis flag. mem_dt_e and errno_e come from the existing mem.svh and errno.svh.
- One natural sub-module, lsu_rd_assemble: per-beat byte-lane capture register plus the final sign/zero extension.

Test Plan:
- Aligned word load: mem[0x10>>2]=0xDEADBEEF, load WORD @0x10 → one beat with m_dt=WORD; rsp_valid at T+2, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Split word store: store WORD 0xAABBCCDD @0x13 → 4 UBYTE beats to 0x13..0x16; aligned reads then return word@0x10[31:24]=0xDD and word@0x14[23:0]=0xAABBCC.
- Split signed half load: word@0x0=0x00803400, load HALF @0x1 → 2 beats; rsp_rdata=0xFFFF8034. Same access as UHALF → 0x00008034.
- Backpressure: hold rsp_ready=0 for 3 cycles → rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; a req_valid pulse during this time is not accepted.
- Reset mid-request: assert rst_n=0 after beat 1 of a split word store @0x21 → outputs return to reset values immediately; only bytes 0x21 and 0x22 are modified; no response.
- Macro undefined: load WORD @0x2 → rsp_valid at T+1, rsp_err=1, rsp_rdata=0; m_we never asserted and no m_addr beat issued.
